mem_bus_arbiter: RTL and testbench

//  Shares one memory port among N_PORTS requesters (default 2: instruction fetch = port 0, data = port 1).

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic PRIO_FIXED = 1'b0;
    localparam logic PRIO_RR    = 1'b1;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: fixed priority (lowest index) or round-robin after ptr.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic        found;
    int unsigned cand;

    // Walk candidates in priority order; the first requesting one wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            if (mode == PRIO_RR) begin
                cand = (32'(ptr) + 32'd1 + 32'(i)) % 32'(N);
            end else begin
                cand = 32'(i);
            end
            for (int j = 0; j < N; j++) begin
                if (!found && (32'(j) == cand) && req[j]) begin
                    found   = 1'b1;
                    gnt[j]  = 1'b1;
                    gnt_idx = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one variable-latency memory port among N_PORTS requesters, one transaction at a time,
// with timeout and misalignment error responses.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [N_PORTS-1:0]                req_valid,
    output logic [N_PORTS-1:0]                req_ready,
    input  logic [N_PORTS-1:0]                req_we,
    input  logic [N_PORTS*AW-1:0]             req_addr,
    input  logic [N_PORTS*DW-1:0]             req_wdata,
    input  logic [N_PORTS*(DW/8)-1:0]         req_be,
    output logic [N_PORTS-1:0]                rsp_valid,
    output logic                              rsp_err,
    output logic [DW-1:0]                     rsp_rdata,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [AW-$clog2(DW/8)-1:0]        mem_addr,
    output logic [DW-1:0]                     mem_wdata,
    output logic [DW/8-1:0]                   mem_be,
    input  logic                              mem_ack,
    input  logic [DW-1:0]                     mem_rdata
);

    localparam int unsigned BW  = DW / 8;
    localparam int unsigned OFS = $clog2(BW);
    localparam int unsigned IW  = idx_width(N_PORTS);
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);
    localparam logic        ARB_MODE = (PRIO_MODE == 32'd1) ? PRIO_RR : PRIO_FIXED;

    state_e            state;
    logic [N_PORTS-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     g_q;
    logic [CW-1:0]     cnt;
    logic              res_err;
    logic [DW-1:0]     res_rdata;

    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic [BW-1:0]     sel_be;
    logic              misaligned;
    logic              timeout_hit;

    rr_arbiter #(
        .N  (N_PORTS),
        .IW (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .mode    (ARB_MODE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = (state == IDLE && reset_n) ? gnt : '0;

    // Mux the granted port's request fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (gnt[p]) begin
                sel_we    = req_we[p];
                sel_addr  = req_addr[p*AW +: AW];
                sel_wdata = req_wdata[p*DW +: DW];
                sel_be    = req_be[p*BW +: BW];
            end
        end
    end

    assign misaligned  = (sel_addr & AW'(BW - 1)) != '0;
    assign timeout_hit = (32'(cnt) + 32'd1) >= (TIMEOUT - 32'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= IW'(N_PORTS - 1);
            g_q       <= '0;
            cnt       <= '0;
            res_err   <= 1'b0;
            res_rdata <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        g_q    <= gnt_idx;
                        rr_ptr <= gnt_idx;
                        cnt    <= '0;
                        if (misaligned) begin
                            res_err   <= 1'b1;
                            res_rdata <= '0;
                            state     <= RESP;
                        end else begin
                            mem_en    <= 1'b1;
                            mem_we    <= sel_we;
                            mem_addr  <= sel_addr[AW-1:OFS];
                            mem_wdata <= sel_wdata;
                            mem_be    <= sel_be;
                            state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // An ack in the timeout cycle still counts as success.
                    if (mem_ack || timeout_hit) begin
                        res_err   <= !mem_ack;
                        res_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    rsp_valid <= N_PORTS'(1) << g_q;
                    rsp_err   <= res_err;
                    rsp_rdata <= res_rdata;
                    cnt       <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter: a 2-port fixed-priority instance and a
// 3-port round-robin instance, checked against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int unsigned TMO_A = 16;
    localparam int unsigned TMO_B = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Instance A: 2 ports, fixed priority
    logic [1:0]  a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [63:0] a_req_addr, a_req_wdata;
    logic [7:0]  a_req_be;
    logic        a_rsp_err, a_mem_en, a_mem_we, a_mem_ack;
    logic [31:0] a_rsp_rdata, a_mem_wdata, a_mem_rdata;
    logic [29:0] a_mem_addr;
    logic [3:0]  a_mem_be;

    // Instance B: 3 ports, round-robin
    logic [2:0]  b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
    logic [95:0] b_req_addr, b_req_wdata;
    logic [11:0] b_req_be;
    logic        b_rsp_err, b_mem_en, b_mem_we, b_mem_ack;
    logic [31:0] b_rsp_rdata, b_mem_wdata, b_mem_rdata;
    logic [29:0] b_mem_addr;
    logic [3:0]  b_mem_be;

    mem_bus_arbiter #(.N_PORTS(2), .AW(32), .DW(32), .PRIO_MODE(0), .TIMEOUT(TMO_A)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_be(a_mem_be),
        .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata)
    );

    mem_bus_arbiter #(.N_PORTS(3), .AW(32), .DW(32), .PRIO_MODE(1), .TIMEOUT(TMO_B)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_be(b_mem_be),
        .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata)
    );

    typedef struct {
        logic [2:0]  ready;
        logic [2:0]  rsp_valid;
        logic        err;
        logic [31:0] rdata;
        logic        en;
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } obs_t;

    int n_checks = 0;
    int n_errors = 0;

    // Model: index of the last accepted port per instance (the round-robin reference point).
    int          exp_last [2];
    logic [2:0]  t_we;
    logic [31:0] t_addr  [4];
    logic [31:0] t_wdata [4];
    logic [3:0]  t_be    [4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_reqs(input int inst, input logic [2:0] mask);
        if (inst == 0) begin
            a_req_valid = mask[1:0];
            a_req_we    = t_we[1:0];
            a_req_addr  = {t_addr[1], t_addr[0]};
            a_req_wdata = {t_wdata[1], t_wdata[0]};
            a_req_be    = {t_be[1], t_be[0]};
        end else begin
            b_req_valid = mask;
            b_req_we    = t_we;
            b_req_addr  = {t_addr[2], t_addr[1], t_addr[0]};
            b_req_wdata = {t_wdata[2], t_wdata[1], t_wdata[0]};
            b_req_be    = {t_be[2], t_be[1], t_be[0]};
        end
    endtask

    task automatic set_mem(input int inst, input logic ack, input logic [31:0] data);
        if (inst == 0) begin
            a_mem_ack   = ack;
            a_mem_rdata = data;
        end else begin
            b_mem_ack   = ack;
            b_mem_rdata = data;
        end
    endtask

    task automatic sample(input int inst, output obs_t o);
        if (inst == 0) begin
            o.ready = {1'b0, a_req_ready};  o.rsp_valid = {1'b0, a_rsp_valid};
            o.err   = a_rsp_err;            o.rdata     = a_rsp_rdata;
            o.en    = a_mem_en;             o.we        = a_mem_we;
            o.addr  = a_mem_addr;           o.wdata     = a_mem_wdata;
            o.be    = a_mem_be;
        end else begin
            o.ready = b_req_ready;          o.rsp_valid = b_rsp_valid;
            o.err   = b_rsp_err;            o.rdata     = b_rsp_rdata;
            o.en    = b_mem_en;             o.we        = b_mem_we;
            o.addr  = b_mem_addr;           o.wdata     = b_mem_wdata;
            o.be    = b_mem_be;
        end
    endtask

    task automatic check_quiet(input int inst, input string tag);
        obs_t o;
        sample(inst, o);
        check_eq($sformatf("%s_i%0d_ready", tag, inst), o.ready, 0);
        check_eq($sformatf("%s_i%0d_rsp_valid", tag, inst), o.rsp_valid, 0);
        check_eq($sformatf("%s_i%0d_err", tag, inst), o.err, 0);
        check_eq($sformatf("%s_i%0d_rdata", tag, inst), o.rdata, 0);
        check_eq($sformatf("%s_i%0d_mem", tag, inst),
                 {o.en, o.we, o.addr, o.be}, 0);
        check_eq($sformatf("%s_i%0d_wdata", tag, inst), o.wdata, 0);
    endtask

    // One complete transaction: offer mask, ack in BUSY cycle ack_k (0 = never), check to response.
    task automatic run_txn(input int inst, input logic [2:0] mask, input int ack_k,
                           input logic [31:0] mdata, output int got_w);
        int          n, tmo, tcyc, w, r_cyc;
        bit          rr, mis, acked, busy;
        logic [31:0] exp_rd;
        obs_t        o;

        n   = (inst == 0) ? 2 : 3;
        tmo = (inst == 0) ? int'(TMO_A) : int'(TMO_B);
        rr  = (inst == 1);
        w   = -1;
        for (int i = 1; i <= n; i++) begin
            int idx;
            idx = rr ? (exp_last[inst] + i) % n : i - 1;
            if (w < 0 && ((mask >> idx) & 3'b001) != 0) w = idx;
        end
        exp_last[inst] = w;

        mis    = t_addr[w[1:0]][1:0] != 2'b00;
        tcyc   = (tmo > 1) ? tmo - 1 : 1;
        acked  = !mis && ack_k >= 1 && ack_k <= tcyc;
        r_cyc  = mis ? 2 : ((acked ? ack_k : tcyc) + 2);
        exp_rd = (acked && !t_we[w[1:0]]) ? mdata : 32'h0;

        @(negedge clk);
        drive_reqs(inst, mask);
        #1;
        sample(inst, o);
        check_eq($sformatf("i%0d_req_ready", inst), o.ready, 3'b001 << w);
        got_w = -1;
        for (int i = 2; i >= 0; i--) if (((o.ready >> i) & 3'b001) != 0) got_w = i;
        @(posedge clk);

        for (int c = 1; c <= r_cyc; c++) begin
            @(negedge clk);
            drive_reqs(inst, 3'b000);
            set_mem(inst, c == ack_k, mdata);
            #1;
            sample(inst, o);
            busy = !mis && (c <= r_cyc - 2);
            check_eq($sformatf("i%0d_mem_en_c%0d", inst, c), o.en, busy);
            if (busy) begin
                check_eq($sformatf("i%0d_mem_addr_c%0d", inst, c), o.addr, t_addr[w[1:0]] >> 2);
                check_eq($sformatf("i%0d_mem_we_c%0d", inst, c), o.we, t_we[w[1:0]]);
                check_eq($sformatf("i%0d_mem_wdata_c%0d", inst, c), o.wdata, t_wdata[w[1:0]]);
                check_eq($sformatf("i%0d_mem_be_c%0d", inst, c), o.be, t_be[w[1:0]]);
            end
            check_eq($sformatf("i%0d_rsp_valid_c%0d", inst, c), o.rsp_valid,
                     (c == r_cyc) ? (3'b001 << w) : 3'b000);
            if (c == r_cyc) begin
                check_eq($sformatf("i%0d_rsp_err", inst), o.err, !acked);
                check_eq($sformatf("i%0d_rsp_rdata", inst), o.rdata, exp_rd);
            end
        end
        set_mem(inst, 1'b0, 32'h0);
    endtask

    task automatic rand_fields(input bit allow_mis);
        for (int p = 0; p < 3; p++) begin
            t_addr[p]  = $urandom & 32'hFFFF_FFFC;
            if (allow_mis && $urandom_range(0, 7) == 0) t_addr[p] |= 32'($urandom_range(1, 3));
            t_wdata[p] = $urandom;
            t_be[p]    = 4'($urandom_range(0, 15));
        end
        t_we = 3'($urandom_range(0, 7));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int order [4];
        order = '{0, 1, 2, 0};

        // Reset with all requesters asserting valid
        reset_n = 1'b0;
        for (int p = 0; p < 4; p++) begin
            t_addr[p] = 32'h0; t_wdata[p] = 32'h0; t_be[p] = 4'h0;
        end
        t_we = 3'b000;
        drive_reqs(0, 3'b011);
        drive_reqs(1, 3'b111);
        set_mem(0, 1'b0, 32'h0);
        set_mem(1, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_quiet(0, "reset");
        check_quiet(1, "reset");
        drive_reqs(0, 3'b000);
        drive_reqs(1, 3'b000);
        reset_n     = 1'b1;
        exp_last[0] = 1;
        exp_last[1] = 2;

        // Round-robin with three contending ports
        for (int k = 0; k < 4; k++) begin
            rand_fields(1'b0);
            run_txn(1, 3'b111, 1, $urandom, w);
            check_eq($sformatf("rr_order_%0d", k), 64'(w), 64'(order[k]));
        end

        for (int k = 0; k < 40; k++) begin
            rand_fields(1'b1);
            run_txn(1, 3'($urandom_range(1, 7)), $urandom_range(0, 4), $urandom, w);
        end

        // Single read from port 1
        t_addr[1] = 32'h40; t_we = 3'b000; t_be[1] = 4'hF; t_wdata[1] = 32'h1234_5678;
        run_txn(0, 3'b010, 3, 32'hDEAD_BEEF, w);

        // Fixed priority under contention
        for (int k = 0; k < 4; k++) begin
            rand_fields(1'b0);
            run_txn(0, 3'b011, 1 + k, $urandom, w);
            check_eq($sformatf("fixed_prio_%0d", k), 64'(w), 64'd0);
        end

        // Timeout, then misaligned write with a stray ack while responding
        rand_fields(1'b0);
        t_we = 3'b000;
        run_txn(0, 3'b001, 0, 32'hCAFE_F00D, w);
        t_addr[0] = 32'h41; t_we = 3'b001;
        run_txn(0, 3'b001, 1, 32'h5555_AAAA, w);

        for (int k = 0; k < 40; k++) begin
            int r, ack_k;
            rand_fields(1'b1);
            r = $urandom_range(0, 9);
            ack_k = (r == 0) ? 0 : (r == 1) ? 15 : (r == 2) ? 16 : $urandom_range(1, 5);
            run_txn(0, 3'($urandom_range(1, 3)), ack_k, $urandom, w);
        end

        // Make sure the held response data is nonzero before the reset check
        t_addr[0] = 32'h80; t_we = 3'b000;
        run_txn(0, 3'b001, 1, 32'hA5A5_5A5A, w);

        // Reset in the middle of BUSY
        t_addr[0] = 32'h100; t_we = 3'b000; t_wdata[0] = 32'h0; t_be[0] = 4'hF;
        @(negedge clk);
        drive_reqs(0, 3'b001);
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            drive_reqs(0, 3'b000);
            #1;
            check_eq($sformatf("midrst_en_c%0d", c), a_mem_en, 1'b1);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_quiet(0, "midrst");
        reset_n     = 1'b1;
        exp_last[0] = 1;
        exp_last[1] = 2;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            check_eq($sformatf("midrst_quiet_c%0d", c), {a_rsp_valid, a_mem_en}, 3'b000);
        end
        t_addr[0] = 32'h200; t_we = 3'b000;
        run_txn(0, 3'b001, 2, 32'h0BAD_F00D, w);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
